// File: rtl/lux_meas_scheduler.sv
// lux_meas_scheduler
// Periodic BH1750 measurement sequencer between the I2C byte master and the
// 16x2 LCD writer. Each period it powers the sensor on, starts a one-time
// high-resolution measurement, waits the conversion time, reads the 16-bit
// count, converts it to five right-aligned ASCII digits and pulses o_tick.
//
// Ports
//   i_clk, i_rst           clock, async active-low reset
//   i_enable               run measurements while high
//   o_i2c_req/rw/addr/wdata request to the I2C master (rw 1 = read 2 bytes)
//   i_i2c_ack/err/rdata    completion pulses and read data {MSB, LSB}
//   o_byte4..o_byte0       ASCII digits, o_byte4 = ten-thousands
//   o_tick                 one-cycle pulse: new display bytes valid
//   o_err                  set by a failed cycle, cleared by a good read
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | parked, waiting for i_enable
// S_PWR    | I2C write 8'h01 (power on)
// S_CMD    | I2C write 8'h20 (one-time H-res measurement)
// S_WAIT   | conversion wait, P_MEAS_WAIT cycles
// S_READ   | I2C read of the 16-bit raw count
// S_CONV   | sequential double-dabble, 16 iterations
// S_OUT    | display bytes and o_tick visible for one cycle
// S_PERIOD | wait for the period counter to expire

module lux_meas_scheduler #(
    parameter logic [6:0]  P_ADDR      = 7'h23,
    parameter int unsigned P_MEAS_WAIT = 9_000_000,
    parameter int unsigned P_PERIOD    = 50_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    output logic        o_i2c_req,
    output logic        o_i2c_rw,
    output logic [6:0]  o_i2c_addr,
    output logic [7:0]  o_i2c_wdata,
    input  logic        i_i2c_ack,
    input  logic        i_i2c_err,
    input  logic [15:0] i_i2c_rdata,
    output logic [7:0]  o_byte4,
    output logic [7:0]  o_byte3,
    output logic [7:0]  o_byte2,
    output logic [7:0]  o_byte1,
    output logic [7:0]  o_byte0,
    output logic        o_tick,
    output logic        o_err
);
    localparam int PW = $clog2(P_PERIOD + 1);
    localparam int WW = $clog2(P_MEAS_WAIT + 1);
    localparam logic [PW-1:0] PER_LOAD  = PW'(P_PERIOD - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(P_MEAS_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PWR, S_CMD, S_WAIT, S_READ, S_CONV, S_OUT, S_PERIOD
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [35:0]   dd_q, dd_d;
    logic          req_q, req_d;
    logic          rw_q, rw_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [39:0]   bytes_q, bytes_d;
    logic          tick_q, tick_d;
    logic          err_q, err_d;
    logic [35:0]   dd_next;
    logic          xfer_ok;
    logic          xfer_fail;

    // One double-dabble iteration on {bcd[19:0], bin[15:0]}.
    function automatic logic [35:0] dd_step(input logic [35:0] v);
        logic [35:0] t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            if (t[16 + 4*i +: 4] >= 4'd5) begin
                t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
            end
        end
        return {t[34:0], 1'b0};
    endfunction

    // Right-aligned ASCII with leading zeros blanked; units digit always shown.
    function automatic logic [39:0] to_ascii(input logic [19:0] bcd);
        logic [39:0] r;
        logic        lead;
        logic [3:0]  d;
        r    = '0;
        lead = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            d = bcd[4*i +: 4];
            if (lead && d == 4'd0) begin
                r[8*i +: 8] = 8'h20;
            end else begin
                lead        = 1'b0;
                r[8*i +: 8] = {4'h3, d};
            end
        end
        r[7:0] = {4'h3, bcd[3:0]};
        return r;
    endfunction

    assign dd_next = dd_step(dd_q);

    // Completion pulses only count while our request is actually up.
    assign xfer_fail = req_q & i_i2c_err;
    assign xfer_ok   = req_q & i_i2c_ack & ~i_i2c_err;

    always_comb begin
        state_d    = state_q;
        per_cnt_d  = (per_cnt_q != '0) ? per_cnt_q - PW'(1) : '0;
        wait_cnt_d = wait_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        dd_d       = dd_q;
        req_d      = 1'b0;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        bytes_d    = bytes_q;
        tick_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_enable) begin
                    state_d   = S_PWR;
                    per_cnt_d = PER_LOAD;
                end
            end
            S_PWR, S_CMD, S_READ: begin
                if (!req_q) begin
                    // First cycle in the state: raise the request next edge.
                    req_d   = 1'b1;
                    rw_d    = (state_q == S_READ);
                    wdata_d = (state_q == S_PWR) ? 8'h01 :
                              (state_q == S_CMD) ? 8'h20 : 8'h00;
                end else if (xfer_fail) begin
                    bytes_d = {5{8'h2D}};
                    err_d   = 1'b1;
                    tick_d  = 1'b1;
                    state_d = S_OUT;
                end else if (xfer_ok) begin
                    case (state_q)
                        S_PWR: state_d = S_CMD;
                        S_CMD: begin
                            state_d    = S_WAIT;
                            wait_cnt_d = WAIT_LOAD;
                        end
                        default: begin
                            state_d   = S_CONV;
                            dd_d      = {20'd0, i_i2c_rdata};
                            bit_cnt_d = 4'd15;
                        end
                    endcase
                end else begin
                    req_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = S_READ;
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end
            S_CONV: begin
                dd_d = dd_next;
                if (bit_cnt_q == 4'd0) begin
                    // Format straight from the final iteration so the tick
                    // lands in the cycle right after the last shift.
                    bytes_d = to_ascii(dd_next[35:16]);
                    tick_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_OUT;
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            S_OUT: begin
                state_d = S_PERIOD;
            end
            S_PERIOD: begin
                if (per_cnt_q == '0) begin
                    if (i_enable) begin
                        state_d   = S_PWR;
                        per_cnt_d = PER_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            per_cnt_q  <= '0;
            wait_cnt_q <= '0;
            bit_cnt_q  <= '0;
            dd_q       <= '0;
            req_q      <= 1'b0;
            rw_q       <= 1'b0;
            wdata_q    <= 8'h00;
            bytes_q    <= {5{8'h20}};
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            dd_q       <= dd_d;
            req_q      <= req_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            bytes_q    <= bytes_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
        end
    end

    assign o_i2c_req   = req_q;
    assign o_i2c_rw    = rw_q;
    assign o_i2c_addr  = P_ADDR;
    assign o_i2c_wdata = wdata_q;
    assign o_byte4     = bytes_q[39:32];
    assign o_byte3     = bytes_q[31:24];
    assign o_byte2     = bytes_q[23:16];
    assign o_byte1     = bytes_q[15:8];
    assign o_byte0     = bytes_q[7:0];
    assign o_tick      = tick_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_lux_meas_scheduler.sv
module tb_lux_meas_scheduler;

    localparam int MEAS     = 20;
    localparam int PER      = 200;
    localparam int F_PER    = 30;
    localparam int CONV_LAT = 17;

    logic        clk = 1'b0;
    logic        rst_n, en, ack, err;
    logic [15:0] rdata;
    logic        req, rw, tick, oerr;
    logic [6:0]  addr;
    logic [7:0]  wdata, b4, b3, b2, b1, b0;

    logic        f_en, f_ack, f_err;
    logic [15:0] f_rdata;
    logic        f_req, f_rw, f_tick, f_oerr;
    logic [6:0]  f_addr;
    logic [7:0]  f_wdata, fb4, fb3, fb2, fb1, fb0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int f_hold = 0;
    logic [39:0] exp_disp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lux_meas_scheduler #(.P_ADDR(7'h23), .P_MEAS_WAIT(MEAS), .P_PERIOD(PER)) u_dut (
        .i_clk(clk), .i_rst(rst_n), .i_enable(en),
        .o_i2c_req(req), .o_i2c_rw(rw), .o_i2c_addr(addr), .o_i2c_wdata(wdata),
        .i_i2c_ack(ack), .i_i2c_err(err), .i_i2c_rdata(rdata),
        .o_byte4(b4), .o_byte3(b3), .o_byte2(b2), .o_byte1(b1), .o_byte0(b0),
        .o_tick(tick), .o_err(oerr)
    );

    // Second instance whose period is shorter than one measurement.
    lux_meas_scheduler #(.P_ADDR(7'h23), .P_MEAS_WAIT(MEAS), .P_PERIOD(F_PER)) u_fast (
        .i_clk(clk), .i_rst(rst_n), .i_enable(f_en),
        .o_i2c_req(f_req), .o_i2c_rw(f_rw), .o_i2c_addr(f_addr), .o_i2c_wdata(f_wdata),
        .i_i2c_ack(f_ack), .i_i2c_err(f_err), .i_i2c_rdata(f_rdata),
        .o_byte4(fb4), .o_byte3(fb3), .o_byte2(fb2), .o_byte1(fb1), .o_byte0(fb0),
        .o_tick(f_tick), .o_err(f_oerr)
    );

    // Auto-responder for the short-period instance: ack in the 2nd request cycle.
    initial begin
        f_ack   = 1'b0;
        f_err   = 1'b0;
        f_rdata = 16'd42;
        forever begin
            @(negedge clk);
            f_ack = 1'b0;
            if (f_req === 1'b1) begin
                f_hold++;
                if (f_hold == 2) f_ack = 1'b1;
            end else begin
                f_hold = 0;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference display: the count printed as a 5-wide right-aligned decimal.
    function automatic logic [39:0] model_bytes(input int unsigned v);
        string s;
        logic [39:0] r;
        s = $sformatf("%5d", v);
        for (int i = 0; i < 5; i++) r[8*(4-i) +: 8] = s[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input string tag, input logic exp_rw, input logic [7:0] exp_wd,
                         input int lat, input bit fail, input logic [15:0] rd, input bit spur,
                         output int req_cyc, output int ack_cyc);
        int n;
        bit held;
        n = 0;
        while (req !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, " req seen"}, {63'd0, req}, 64'd1);
        req_cyc = cyc;
        check({tag, " rw"}, {63'd0, rw}, {63'd0, exp_rw});
        check({tag, " addr"}, {57'd0, addr}, 64'h23);
        if (exp_rw == 1'b0) check({tag, " wdata"}, {56'd0, wdata}, {56'd0, exp_wd});
        held = 1'b1;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            held = held && (req === 1'b1) && (rw === exp_rw);
        end
        check({tag, " req held"}, {63'd0, held}, 64'd1);
        ack     = !fail;
        err     = fail;
        rdata   = rd;
        ack_cyc = cyc;
        @(negedge clk);
        ack   = 1'b0;
        err   = spur;
        rdata = 16'($urandom);
        check({tag, " req drop"}, {63'd0, req}, 64'd0);
        if (spur) begin
            @(negedge clk);
            err = 1'b0;
        end
    endtask

    task automatic wait_tick(input string tag, output int tcyc);
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " tick seen"}, {63'd0, tick}, 64'd1);
        tcyc = cyc;
    endtask

    task automatic run_period(input string tag, input int lat, input int unsigned val,
                              input bit spur, input bit drop_en, output int tick_cyc);
        int rq_p, ak_p, rq_c, ak_c, rq_r, ak_r;
        serve({tag, " pwr"}, 1'b0, 8'h01, lat, 1'b0, 16'h0, spur, rq_p, ak_p);
        serve({tag, " cmd"}, 1'b0, 8'h20, lat, 1'b0, 16'h0, 1'b0, rq_c, ak_c);
        check({tag, " req gap"}, 64'(rq_c - ak_p), 64'd2);
        if (drop_en) en = 1'b0;
        serve({tag, " rd"}, 1'b1, 8'h00, lat, 1'b0, 16'(val), 1'b0, rq_r, ak_r);
        check({tag, " wait len"}, 64'(rq_r - ak_c), 64'(MEAS + 2));
        check({tag, " bytes hold"}, {24'd0, b4, b3, b2, b1, b0}, {24'd0, exp_disp});
        wait_tick(tag, tick_cyc);
        check({tag, " conv lat"}, 64'(tick_cyc - ak_r), 64'(CONV_LAT));
        exp_disp = model_bytes(val);
        check({tag, " bytes"}, {24'd0, b4, b3, b2, b1, b0}, {24'd0, exp_disp});
        check({tag, " err clr"}, {63'd0, oerr}, 64'd0);
        @(negedge clk);
        check({tag, " tick 1cyc"}, {63'd0, tick}, 64'd0);
    endtask

    initial begin
        int t_prev, t_cur, rq, ak, n, ft;
        bit saw_req;
        logic [15:0] v;

        rst_n = 1'b0; en = 1'b0; f_en = 1'b0;
        ack = 1'b0; err = 1'b0; rdata = 16'h0;
        exp_disp = {5{8'h20}};
        repeat (3) @(negedge clk);
        check("rst req", {63'd0, req}, 64'd0);
        check("rst rw", {63'd0, rw}, 64'd0);
        check("rst wdata", {56'd0, wdata}, 64'd0);
        check("rst bytes", {24'd0, b4, b3, b2, b1, b0}, {24'd0, {5{8'h20}}});
        check("rst tick", {63'd0, tick}, 64'd0);
        check("rst err", {63'd0, oerr}, 64'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle no req", {63'd0, req}, 64'd0);

        en = 1'b1; f_en = 1'b1;
        run_period("p100", 5, 100, 1'b1, 1'b0, t_prev);
        run_period("p0", 5, 0, 1'b0, 1'b0, t_cur);
        check("spacing p0", 64'(t_cur - t_prev), 64'(PER));
        t_prev = t_cur;
        run_period("p65535", 5, 65535, 1'b1, 1'b0, t_cur);
        check("spacing p65535", 64'(t_cur - t_prev), 64'(PER));
        t_prev = t_cur;
        run_period("p9999", 5, 9999, 1'b0, 1'b0, t_cur);
        check("spacing p9999", 64'(t_cur - t_prev), 64'(PER));
        t_prev = t_cur;
        for (int i = 0; i < 3; i++) begin
            v = 16'($urandom);
            run_period("prand", 5, v, 1'b0, 1'b0, t_cur);
            check("spacing rand", 64'(t_cur - t_prev), 64'(PER));
            t_prev = t_cur;
        end

        // Failed command write.
        serve("e pwr", 1'b0, 8'h01, 5, 1'b0, 16'h0, 1'b0, rq, ak);
        serve("e cmd", 1'b0, 8'h20, 5, 1'b1, 16'h0, 1'b0, rq, ak);
        check("err tick", {63'd0, tick}, 64'd1);
        exp_disp = {5{8'h2D}};
        check("err bytes", {24'd0, b4, b3, b2, b1, b0}, {24'd0, exp_disp});
        check("err flag", {63'd0, oerr}, 64'd1);
        repeat (10) @(negedge clk);
        check("err flag held", {63'd0, oerr}, 64'd1);
        check("err tick once", {63'd0, tick}, 64'd0);
        run_period("after err", 3, 12345, 1'b0, 1'b0, t_cur);

        // Enable dropped mid-cycle: finish this one, then park.
        run_period("drop", 4, 777, 1'b0, 1'b1, t_cur);
        saw_req = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (req === 1'b1) saw_req = 1'b1;
        end
        check("parked", {63'd0, saw_req}, 64'd0);

        // Async reset while the read request is up.
        en = 1'b1;
        serve("r pwr", 1'b0, 8'h01, 5, 1'b0, 16'h0, 1'b0, rq, ak);
        serve("r cmd", 1'b0, 8'h20, 5, 1'b0, 16'h0, 1'b0, rq, ak);
        n = 0;
        while (req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("r rd req", {63'd0, req}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("r req async", {63'd0, req}, 64'd0);
        check("r bytes async", {24'd0, b4, b3, b2, b1, b0}, {24'd0, {5{8'h20}}});
        @(negedge clk);
        rst_n = 1'b1;
        exp_disp = {5{8'h20}};
        run_period("r restart", 5, 31, 1'b0, 1'b0, t_cur);

        // Short period: next power-on request right after the tick.
        n = 0;
        while (f_tick !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fast tick", {63'd0, f_tick}, 64'd1);
        ft = cyc;
        check("fast bytes", {24'd0, fb4, fb3, fb2, fb1, fb0}, {24'd0, model_bytes(42)});
        check("fast err", {63'd0, f_oerr}, 64'd0);
        n = 0;
        while (f_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fast next req", 64'(cyc - ft), 64'd3);
        check("fast next wdata", {56'd0, f_wdata}, 64'h01);
        check("fast next rw", {63'd0, f_rw}, 64'd0);
        check("fast addr", {57'd0, f_addr}, 64'h23);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
